player_motion: RTL and testbench
================================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameter STEP, default 8, pixels moved per accepted move command.
REQ-002 Parameter FIFO_DEPTH, default 4, command queue depth (power of two, 2..16).
REQ-003 Parameters X_MIN 330, X_MAX 1210, Y_MIN 220, Y_MAX 620: legal sprite top-left range inside the 960x480 arena walls, for a 60x60 sprite.
REQ-004 i_clk  in  1  pixel clock (108 MHz); the block has one clock; reset is synchronous and active-high.
REQ-005 i_rst  in  1  synchronous active-high reset, sampled on rising i_clk.
REQ-006 i_frame_tick  in  1  one-cycle pulse, once per frame, from the timing generator.
REQ-007 i_cmd_valid  in  1  command valid.
REQ-008 i_cmd  in  3  command: 0 none, 1 up, 2 down, 3 left, 4 right, 5 recenter; codes 6-7 are treated as none.
REQ-009 o_cmd_ready  out  1  queue can accept a command.
REQ-010 o_player_x  out  12  sprite top-left x, consumed by the renderer.
REQ-011 o_player_y  out  12  sprite top-left y, consumed by the renderer.
REQ-012 o_pos_upd  out  1  one-cycle pulse when o_player_x/o_player_y change register value.
REQ-013 o_tick_miss  out  1  one-cycle pulse when a frame tick arrives while the FSM is not IDLE.
REQ-014 o_fifo_count  out  5  number of queued commands.

Function
REQ-015 Handshake: a command is accepted on a rising edge where i_cmd_valid && o_cmd_ready; o_cmd_ready = (count != FIFO_DEPTH), registered-count based.
REQ-016 An accepted command is written at the tail of the FIFO in order; valid while not ready is held by the source and never dropped by the block.
REQ-017 FSM states: IDLE, FETCH, APPLY; IDLE->FETCH on i_frame_tick with count != 0; FETCH->APPLY unconditionally; APPLY->IDLE unconditionally.
REQ-018 In FETCH, the head command is latched and popped; count decrements unless a push is accepted in the same cycle (net 0).
REQ-019 In APPLY, the new position is computed; the registered position and o_pos_upd take effect on the next edge.
REQ-020 Latency: tick high in cycle T (IDLE, nonempty) -> new position visible and o_pos_upd high in cycle T+3.
REQ-021 Exactly one command is consumed per frame tick; a tick with an empty FIFO causes no change and no o_pos_upd.
REQ-022 A tick coinciding with the first push into an empty FIFO sees count 0; no update occurs that frame.
REQ-023 A tick in FETCH or APPLY is ignored and o_tick_miss pulses in the following cycle.
REQ-024 Arithmetic uses 13-bit signed intermediates; up = y-STEP, down = y+STEP, left = x-STEP, right = x+STEP; recenter = (770,420).
REQ-025 Clamp mode: a result < MIN becomes MIN, and a result > MAX becomes MAX.
REQ-026 o_pos_upd pulses only if the resulting position differs from the current one; commands that are none, codes 6-7, or clamped-at-wall produce no pulse.

Reset
REQ-027 While i_rst is high: FSM is IDLE, FIFO is flushed (count 0), o_cmd_ready=1, o_player_x=770, o_player_y=420, o_pos_upd=0, o_tick_miss=0.
REQ-028 Reset asserted mid-FETCH or mid-APPLY aborts the update; the latched command is discarded and not replayed.
REQ-029 A push presented during reset is not accepted.

Configuration
REQ-030 Macro PLAYER_WRAP_EN: when defined, a result > MAX wraps to MIN and a result < MIN wraps to MAX, per axis; when undefined, the clamp of REQ-025 applies; all other behaviour is identical.

Verification
REQ-031 After reset, push right, then tick at T -> o_player_x=778 at T+3, o_pos_upd high only at T+3, o_player_y=420.
REQ-032 Push 5 commands back-to-back with no tick -> 4 accepted, o_cmd_ready=0 after the 4th, o_fifo_count=4; the 5th is held until the next pop.
REQ-033 Recenter, then 56 consecutive left commands, one per frame tick -> without PLAYER_WRAP_EN x stops at 330 with no pulse once clamped; with PLAYER_WRAP_EN, the 56th left (x 330->322) wraps x to 1210.
REQ-034 Tick in T, second tick in T+1 -> o_tick_miss high in T+2, exactly one command consumed.
REQ-035 Queue up,up; tick; assert i_rst at T+2 -> position 770/420, count 0, no o_pos_upd after reset release.
REQ-036 Tick with an empty FIFO plus code-6 and none commands -> no position change, no o_pos_upd, count decrements for each consumed command.

Source files
------------

// File: rtl/player_motion.sv
// Player sprite motion: queues move commands and applies one per frame tick, with wall clamping.
// Define PLAYER_WRAP_EN to wrap the sprite to the opposite wall instead of clamping it.
module player_motion #(
  parameter int STEP       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int X_MIN      = 330,
  parameter int X_MAX      = 1210,
  parameter int Y_MIN      = 220,
  parameter int Y_MAX      = 620
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd,
  output logic        o_cmd_ready,
  output logic [11:0] o_player_x,
  output logic [11:0] o_player_y,
  output logic        o_pos_upd,
  output logic        o_tick_miss,
  output logic [4:0]  o_fifo_count,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a command transfers on a rising edge where i_cmd_valid && o_cmd_ready;
  // the source holds i_cmd stable while valid is high and ready is low.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [12:0] L_XMIN = 13'(X_MIN);
  localparam logic signed [12:0] L_XMAX = 13'(X_MAX);
  localparam logic signed [12:0] L_YMIN = 13'(Y_MIN);
  localparam logic signed [12:0] L_YMAX = 13'(Y_MAX);
  localparam logic signed [12:0] L_STEP = 13'(STEP);
  localparam logic [11:0] HOME_X = 12'd770;
  localparam logic [11:0] HOME_Y = 12'd420;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_APPLY = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]  r_count;
  logic [2:0]  r_cmd;
  logic [11:0] r_x, r_y;
  logic        r_pos_upd, r_tick_miss;

  logic        w_push, w_pop;
  logic signed [12:0] w_cx, w_cy, w_nx, w_ny, w_fx, w_fy;

  assign o_cmd_ready  = (r_count != 5'(FIFO_DEPTH));
  assign w_push       = i_cmd_valid && o_cmd_ready;
  assign w_pop        = (r_state == S_FETCH);
  assign o_player_x   = r_x;
  assign o_player_y   = r_y;
  assign o_pos_upd    = r_pos_upd;
  assign o_tick_miss  = r_tick_miss;
  assign o_fifo_count = r_count;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_tick && r_count != 5'd0) w_next = S_FETCH;
      S_FETCH: w_next = S_APPLY;
      S_APPLY: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_cx = signed'({1'b0, r_x});
  assign w_cy = signed'({1'b0, r_y});

  always_comb begin
    w_nx = w_cx;
    w_ny = w_cy;
    case (r_cmd)
      3'd1: w_ny = w_cy - L_STEP;
      3'd2: w_ny = w_cy + L_STEP;
      3'd3: w_nx = w_cx - L_STEP;
      3'd4: w_nx = w_cx + L_STEP;
      3'd5: begin
        w_nx = signed'({1'b0, HOME_X});
        w_ny = signed'({1'b0, HOME_Y});
      end
      default: ;
    endcase
`ifdef PLAYER_WRAP_EN
    if (w_nx > L_XMAX)      w_fx = L_XMIN;
    else if (w_nx < L_XMIN) w_fx = L_XMAX;
    else                    w_fx = w_nx;
    if (w_ny > L_YMAX)      w_fy = L_YMIN;
    else if (w_ny < L_YMIN) w_fy = L_YMAX;
    else                    w_fy = w_ny;
`else
    if (w_nx > L_XMAX)      w_fx = L_XMAX;
    else if (w_nx < L_XMIN) w_fx = L_XMIN;
    else                    w_fx = w_nx;
    if (w_ny > L_YMAX)      w_fy = L_YMAX;
    else if (w_ny < L_YMIN) w_fy = L_YMIN;
    else                    w_fy = w_ny;
`endif
  end

  // Storage needs no reset; only the pointers and count define occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= i_cmd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 5'd0;
      r_cmd       <= 3'd0;
      r_x         <= HOME_X;
      r_y         <= HOME_Y;
      r_pos_upd   <= 1'b0;
      r_tick_miss <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_tick_miss <= i_frame_tick && (r_state != S_IDLE);
      r_pos_upd   <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_cmd    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + 5'(w_push) - 5'(w_pop);
      if (r_state == S_APPLY) begin
        r_x       <= w_fx[11:0];
        r_y       <= w_fy[11:0];
        r_pos_upd <= (w_fx[11:0] != r_x) || (w_fy[11:0] != r_y);
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed scenarios then random traffic against a frame-level model.
module tb_player_motion;
  localparam int STEP = 8, FIFO_DEPTH = 4;
  localparam int X_MIN = 330, X_MAX = 1210, Y_MIN = 220, Y_MAX = 620;

  logic        clk = 1'b0;
  logic        i_rst, i_frame_tick, i_cmd_valid;
  logic [2:0]  i_cmd;
  logic        o_cmd_ready, o_pos_upd, o_tick_miss;
  logic [11:0] o_player_x, o_player_y;
  logic [4:0]  o_fifo_count;
  logic [1:0]  o_dbg_state;

  int checks = 0, errors = 0;

  // Model: position, queued commands, command in flight and edges left until the frame finishes.
  int m_x, m_y, m_cmd, m_busy;
  int m_q[$];
  int src_q[$];
  bit e_upd, e_miss;

  player_motion #(.STEP(STEP), .FIFO_DEPTH(FIFO_DEPTH), .X_MIN(X_MIN), .X_MAX(X_MAX),
                  .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick), .i_cmd_valid(i_cmd_valid),
    .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready), .o_player_x(o_player_x), .o_player_y(o_player_y),
    .o_pos_upd(o_pos_upd), .o_tick_miss(o_tick_miss), .o_fifo_count(o_fifo_count),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
`ifdef PLAYER_WRAP_EN
    if (v > hi) return lo;
    if (v < lo) return hi;
`else
    if (v > hi) return hi;
    if (v < lo) return lo;
`endif
    return v;
  endfunction

  task automatic apply_model();
    int nx = m_x, ny = m_y;
    case (m_cmd)
      1: ny = m_y - STEP;
      2: ny = m_y + STEP;
      3: nx = m_x - STEP;
      4: nx = m_x + STEP;
      5: begin nx = 770; ny = 420; end
      default: ;
    endcase
    nx = lim(nx, X_MIN, X_MAX);
    ny = lim(ny, Y_MIN, Y_MAX);
    e_upd = (nx != m_x) || (ny != m_y);
    m_x = nx;
    m_y = ny;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare at the falling edge.
  task automatic step(input bit tick, input bit rst);
    bit acc;
    int pre;
    i_frame_tick = tick;
    i_rst        = rst;
    i_cmd_valid  = (src_q.size() != 0);
    i_cmd        = i_cmd_valid ? 3'(src_q[0]) : 3'd0;
    pre    = m_q.size();
    acc    = !rst && i_cmd_valid && (pre != FIFO_DEPTH);
    e_upd  = 0;
    e_miss = 0;
    if (rst) begin
      m_q.delete();
      m_x = 770; m_y = 420; m_busy = 0;
    end else begin
      e_miss = tick && (m_busy != 0);
      if (m_busy == 2) m_cmd = m_q.pop_front();
      if (m_busy == 1) apply_model();
      if (acc) m_q.push_back(src_q[0]);
      if (m_busy > 0) m_busy--;
      else if (tick && pre != 0) m_busy = 2;
    end
    if (acc) void'(src_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    check("pos_x", int'(o_player_x), m_x);
    check("pos_y", int'(o_player_y), m_y);
    check("pos_upd", int'(o_pos_upd), int'(e_upd));
    check("tick_miss", int'(o_tick_miss), int'(e_miss));
    check("fifo_count", int'(o_fifo_count), m_q.size());
    check("cmd_ready", int'(o_cmd_ready), int'(m_q.size() != FIFO_DEPTH));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_frame_tick = 1'b0; i_cmd_valid = 1'b0; i_cmd = 3'd0;
    m_x = 770; m_y = 420; m_cmd = 0; m_busy = 0;
    step(0, 1); step(0, 1); step(0, 1);

    // push right, tick: x moves to 778 three cycles later
    src_q.push_back(4);
    step(0, 0);
    step(1, 0);
    run(2);
    check("right_x_const", int'(o_player_x), 778);
    run(2);

    // five back-to-back pushes, the fifth waits for a pop
    for (int i = 0; i < 5; i++) src_q.push_back(1 + (i % 4));
    run(6);
    check("full_count_const", int'(o_fifo_count), FIFO_DEPTH);
    check("full_ready_const", int'(o_cmd_ready), 0);
    for (int i = 0; i < 5; i++) begin step(1, 0); run(3); end

    // recenter then 56 lefts, one per frame
    src_q.push_back(5);
    step(0, 0); step(1, 0); run(3);
    for (int i = 0; i < 56; i++) begin
      src_q.push_back(3);
      step(0, 0); step(1, 0); run(3);
    end
`ifdef PLAYER_WRAP_EN
    check("left_wall_const", int'(o_player_x), X_MAX);
`else
    check("left_wall_const", int'(o_player_x), X_MIN);
`endif

    // back-to-back ticks: second one is missed
    src_q.push_back(2); src_q.push_back(2);
    run(2);
    step(1, 0); step(1, 0); run(4);
    step(1, 0); run(4);

    // reset during the frame aborts the update
    src_q.push_back(1); src_q.push_back(1);
    run(2);
    step(1, 0); step(0, 0);
    step(0, 1); step(0, 1);
    run(4);
    step(1, 0); run(4);

    // empty tick, then code 6 and none commands
    step(1, 0); run(3);
    src_q.push_back(6); src_q.push_back(0);
    run(2);
    step(1, 0); run(3); step(1, 0); run(3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (src_q.size() < 3 && $urandom_range(0, 2) == 0) src_q.push_back($urandom_range(0, 7));
      step($urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
    end
    run(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
